// File: rtl/rotate_arbiter.sv
// rotate_arbiter: two-requester round-robin front end that drives a shared 100-bit load/rotate register.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester command handshake (bit i = requester i)
//   reqN_data/dir/amt   : command word, direction (0 right, 1 left), step count
//   rsp_valid/rsp_ready : result handshake; rsp_id names the issuing requester, rsp_data the rotated word
//   rot_load/ena/data   : rotator controls; rot_q is the rotator output
//   busy                : high whenever the FSM is not in IDLE
//   Optional macro ROT_SHORTPATH_EN: rotate the short way round (at most WIDTH/2 steps).
module rotate_arbiter #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req0_dir,
    input  logic             req1_dir,
    input  logic [CNT_W-1:0] req0_amt,
    input  logic [CNT_W-1:0] req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rot_load,
    output logic [1:0]       rot_ena,
    output logic [WIDTH-1:0] rot_data,
    input  logic [WIDTH-1:0] rot_q,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, RESP} state_t;
    state_t           state_q;
    logic             last_q, dir_q, rsp_valid_q, rsp_id_q, rot_load_q;
    logic [1:0]       rot_ena_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] rot_data_q;
    logic             grant_d, dir_sel, dir_d;
    logic [CNT_W-1:0] amt_sel, amt_d;
`ifdef ROT_SHORTPATH_EN
    localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] H_C = CNT_W'(WIDTH / 2);
    logic [CNT_W-1:0] amt_mod;
`endif
    always_comb begin
        // on a tie the requester that was not served last wins
        grant_d = &req_valid ? ~last_q : req_valid[1];
        dir_sel = grant_d ? req1_dir : req0_dir;
        amt_sel = grant_d ? req1_amt : req0_amt;
`ifdef ROT_SHORTPATH_EN
        // amt < 2*WIDTH, so one conditional subtract reduces it modulo WIDTH
        amt_mod = amt_sel >= W_C ? amt_sel - W_C : amt_sel;
        dir_d   = amt_mod > H_C ? ~dir_sel : dir_sel;
        amt_d   = amt_mod > H_C ? W_C - amt_mod : amt_mod;
`else
        dir_d   = dir_sel;
        amt_d   = amt_sel;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rot_load_q  <= 1'b0;
            rot_ena_q   <= 2'b00;
            rem_q       <= '0;
            rot_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req_valid) begin
                    state_q    <= LOAD;
                    rot_load_q <= 1'b1;
                    rot_data_q <= grant_d ? req1_data : req0_data;
                    dir_q      <= dir_d;
                    rem_q      <= amt_d;
                    rsp_id_q   <= grant_d;
                end
                LOAD: begin
                    rot_load_q <= 1'b0;
                    if (rem_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q   <= ROTATE;
                        rot_ena_q <= dir_q ? 2'b10 : 2'b01;
                    end
                end
                ROTATE: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q     <= RESP;
                        rot_ena_q   <= 2'b00;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    last_q      <= rsp_id_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready = (state_q == IDLE && |req_valid) ? {grant_d, ~grant_d} : 2'b00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    // the rotator holds still in RESP, so its output can be forwarded directly
    assign rsp_data  = rsp_valid_q ? rot_q : '0;
    assign rot_load  = rot_load_q;
    assign rot_ena   = rot_ena_q;
    assign rot_data  = rot_data_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_rotate_arbiter.sv
// tb_rotate_arbiter: randomized self-checking bench for rotate_arbiter with a behavioural rotator and reference model.
module tb_rotate_arbiter;
    localparam int W = 100;
    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid, req_ready;
    logic [W-1:0]   req0_data, req1_data, rsp_data, rot_data, rq;
    logic           req0_dir, req1_dir, rsp_valid, rsp_ready, rsp_id, rot_load, busy;
    logic [6:0]     req0_amt, req1_amt;
    logic [1:0]     rot_ena;
    int             checks = 0;
    int             failures = 0;
    logic           last = 1'b1;

    rotate_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_data(req0_data), .req1_data(req1_data), .req0_dir(req0_dir), .req1_dir(req1_dir),
        .req0_amt(req0_amt), .req1_amt(req1_amt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rot_load(rot_load), .rot_ena(rot_ena),
        .rot_data(rot_data), .rot_q(rq), .busy(busy)
    );

    always #5 clk = ~clk;

    // shared rotator: no reset, load has priority, 01 rotates right, 10 rotates left
    always @(posedge clk) begin
        if (rot_load) rq <= rot_data;
        else if (rot_ena == 2'b01) rq <= {rq[0], rq[W-1:1]};
        else if (rot_ena == 2'b10) rq <= {rq[W-2:0], rq[W-1]};
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d, input logic dir, input int amt);
        int n;
        n = amt % W;
        if (n == 0) return d;
        return dir ? ((d << n) | (d >> (W - n))) : ((d >> n) | (d << (W - n)));
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // entered and left one tick after the edge that starts an IDLE cycle
    task automatic xact(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic r0, input logic r1, input logic [6:0] a0, input logic [6:0] a1,
                        input int hold);
        logic g, dr;
        logic [W-1:0] d, expd;
        int a, n, cyc;
        logic [1:0] code;
        req_valid = v; req0_data = d0; req1_data = d1;
        req0_dir = r0; req1_dir = r1; req0_amt = a0; req1_amt = a1;
        #1;
        g  = (v == 2'b11) ? ~last : v[1];
        d  = g ? d1 : d0;
        dr = g ? r1 : r0;
        a  = int'(g ? a1 : a0);
        expd = rot_ref(d, dr, a);
`ifdef ROT_SHORTPATH_EN
        n = a % W;
        if (n > W / 2) begin cyc = W - n; code = dr ? 2'b01 : 2'b10; end
        else begin cyc = n; code = dr ? 2'b10 : 2'b01; end
`else
        cyc  = a;
        code = dr ? 2'b10 : 2'b01;
`endif
        check("grant", W'(req_ready), W'(g ? 2'b10 : 2'b01));
        step();
        req0_data = rnd_word(); req1_data = rnd_word();
        req0_dir = 1'($urandom); req1_dir = 1'($urandom);
        req0_amt = 7'($urandom); req1_amt = 7'($urandom);
        #1;
        check("load_ctl", W'({req_ready, rot_load, rot_ena}), W'(5'b00100));
        check("load_data", rot_data, d);
        check("load_busy", W'(busy), W'(1));
        check("load_rsp", W'({rsp_valid, rsp_data}), '0);
        step();
        n = 0;
        while (!rsp_valid && n < 300) begin
            check("rot_ctl", W'({req_ready, rot_load, rot_ena}), W'({3'b000, code}));
            rsp_ready = 1'($urandom);
            n++;
            step();
        end
        rsp_ready = 1'b0;
        #1;
        check("rot_cycles", W'(n), W'(cyc));
        check("rsp_valid", W'(rsp_valid), W'(1));
        check("rsp_data", rsp_data, expd);
        check("rsp_id", W'(rsp_id), W'(g));
        check("rsp_ctl", W'({req_ready, rot_load, rot_ena}), '0);
        for (int i = 0; i < hold; i++) begin
            step();
            #1;
            check("hold_valid", W'(rsp_valid), W'(1));
            check("hold_data", rsp_data, expd);
            check("hold_ctl", W'({req_ready, rot_load, rot_ena}), '0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        last = g;
        #1;
        check("idle_state", W'({rsp_valid, busy}), '0);
        check("idle_data", rsp_data, '0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_data = '0; req1_data = '0; req0_dir = 1'b0; req1_dir = 1'b0;
        req0_amt = '0; req1_amt = '0;
        repeat (3) step();
        #1;
        check("rst_ctl", W'({req_ready, rot_load, rot_ena, busy}), '0);
        check("rst_rsp", W'({rsp_valid, rsp_id}), '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rot_data", rot_data, '0);
        reset = 1'b0;
        step();
        // round robin with both requesters permanently valid: ids 0,1,0,1
        for (int i = 0; i < 4; i++)
            xact(2'b11, rnd_word(), rnd_word(), 1'($urandom), 1'($urandom),
                 7'($urandom_range(0, 20)), 7'($urandom_range(0, 20)), 0);
        // single right rotate by one
        xact(2'b01, W'(1), '0, 1'b0, 1'b0, 7'd1, 7'd0, 0);
        // zero amount from requester 1
        xact(2'b10, '0, W'(100'hABCD), 1'b0, 1'b0, 7'd0, 7'd0, 0);
        // five cycles of backpressure
        xact(2'b01, rnd_word(), '0, 1'b1, 1'b0, 7'd7, 7'd0, 5);
        // long left rotate that the short path turns into one right step
        xact(2'b01, W'(1), '0, 1'b1, 1'b0, 7'd99, 7'd0, 0);
        // amounts at and beyond WIDTH
        xact(2'b10, '0, rnd_word(), 1'b0, 1'b1, 7'd0, 7'd100, 0);
        xact(2'b01, rnd_word(), '0, 1'b0, 1'b0, 7'd127, 7'd0, 1);
        xact(2'b10, '0, rnd_word(), 1'b0, 1'b0, 7'd0, 7'd50, 0);
        xact(2'b01, rnd_word(), '0, 1'b1, 1'b0, 7'd51, 7'd0, 0);
        // reset during ROTATE drops the command
        req_valid = 2'b01; req0_data = rnd_word(); req0_dir = 1'b0; req0_amt = 7'd50;
        step();
        req_valid = 2'b00;
        repeat (10) step();
        #1;
        check("mid_rot_ena", W'(rot_ena), W'(2'b01));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_ctl", W'({busy, rot_load, rot_ena, req_ready}), '0);
        check("mid_rst_rsp", W'(rsp_valid), '0);
        last = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            step();
            seen |= rsp_valid | busy;
        end
        check("mid_rst_quiet", W'(seen), '0);
        xact(2'b11, rnd_word(), rnd_word(), 1'b1, 1'b0, 7'd13, 7'd40, 0);
        // random traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 2'b00;
                step();
                #1;
                check("gap_ready", W'(req_ready), '0);
            end
            xact(2'($urandom_range(1, 3)), rnd_word(), rnd_word(), 1'($urandom), 1'($urandom),
                 7'($urandom), 7'($urandom), $urandom_range(0, 3));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
